// File: rtl/tcb_lite_lib_arbiter_rr.sv
// Round-robin arbiter with bus-lock for the TCB-Lite STAR interconnect.
// Combinational grant; the granted index follows a fixed-delay response pipeline.
module tcb_lite_lib_arbiter_rr #(
  parameter int unsigned IFN    = 2,
  parameter int unsigned DLY    = 1,
  parameter int unsigned MAXBST = 8,
  localparam int unsigned IFL   = $clog2(IFN)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [IFN-1:0] req_vld_i,
  input  logic [IFN-1:0] req_lck_i,
  input  logic           man_rdy_i,
  output logic [IFN-1:0] gnt_o,
  output logic [IFL-1:0] sel_o,
  output logic           man_vld_o,
  output logic           rsp_vld_o,
  output logic [IFL-1:0] rsp_sel_o,
  output logic           lck_act_o
);

  typedef enum logic [0:0] {StArb, StLock} state_e;

  state_e         state_q, state_d;
  logic [IFL-1:0] ptr_q, ptr_d;
  logic [IFL-1:0] own_q, own_d;
  logic [7:0]     bst_q, bst_d;

  logic [IFL-1:0] idx;
  logic [IFL-1:0] arb_idx;
  logic           arb_hit;
  logic [IFL-1:0] gnt_idx;
  logic           gnt_any;
  logic           vld;
  logic           xfer;

  // Rotating search from ptr+1; explicit wrap keeps non-power-of-2 IFN in range.
  always_comb begin
    idx     = ptr_q;
    arb_idx = ptr_q;
    arb_hit = 1'b0;
    for (int unsigned k = 0; k < IFN; k++) begin
      idx = (idx == IFL'(IFN - 1)) ? '0 : idx + 1'b1;
      if (!arb_hit && req_vld_i[idx]) begin
        arb_hit = 1'b1;
        arb_idx = idx;
      end
    end
  end

  always_comb begin
    gnt_idx = arb_idx;
    gnt_any = arb_hit;
    if (state_q == StLock) begin
      gnt_idx = own_q;
      gnt_any = 1'b1;
    end
  end

  assign vld  = rst_ni & gnt_any & req_vld_i[gnt_idx];
  assign xfer = vld & man_rdy_i;

  always_comb begin
    gnt_o = '0;
    if (rst_ni && gnt_any) gnt_o[gnt_idx] = 1'b1;
  end

  assign sel_o     = rst_ni ? gnt_idx : '0;
  assign man_vld_o = vld;
  assign lck_act_o = rst_ni & (state_q == StLock);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    bst_d   = bst_q;
    if (xfer) begin
      ptr_d = gnt_idx;
      unique case (state_q)
        StArb: begin
          if (req_lck_i[gnt_idx]) begin
            state_d = StLock;
            own_d   = gnt_idx;
            bst_d   = 8'd1;
          end
        end
        StLock: begin
          if (req_lck_i[own_q] && (bst_q < 8'(MAXBST))) begin
            bst_d = bst_q + 8'd1;
          end else begin
            state_d = StArb;
            bst_d   = 8'd0;
          end
        end
        default: state_d = StArb;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StArb;
      ptr_q   <= IFL'(IFN - 1);
      own_q   <= '0;
      bst_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      bst_q   <= bst_d;
    end
  end

  if (DLY == 0) begin : g_rsp_comb
    assign rsp_vld_o = xfer;
    assign rsp_sel_o = sel_o;
  end else begin : g_rsp_pipe
    logic [DLY-1:0]          pv_q;
    logic [DLY-1:0][IFL-1:0] ps_q;

    // Advances every cycle: response delay on the bus is fixed.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        pv_q <= '0;
        ps_q <= '0;
      end else begin
        pv_q[0] <= xfer;
        ps_q[0] <= gnt_idx;
        for (int i = 1; i < DLY; i++) begin
          pv_q[i] <= pv_q[i-1];
          ps_q[i] <= ps_q[i-1];
        end
      end
    end

    assign rsp_vld_o = rst_ni & pv_q[DLY-1];
    assign rsp_sel_o = rst_ni ? ps_q[DLY-1] : '0;
  end

endmodule

// File: tb/tb_tcb_lite_lib_arbiter_rr.sv
// Directed bench for tcb_lite_lib_arbiter_rr: three parameterisations share one stimulus bus.
module tb_tcb_lite_lib_arbiter_rr;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_vld;
  logic [3:0] req_lck;
  logic       man_rdy;

  logic [3:0] a_gnt, b_gnt;
  logic [2:0] c_gnt;
  logic [1:0] a_sel, b_sel, c_sel, a_rs, b_rs, c_rs;
  logic       a_mv, b_mv, c_mv, a_rv, b_rv, c_rv, a_lk, b_lk, c_lk;

  int n_vec;
  int n_err;

  // A: main checks, B: deep response pipeline, C: non-power-of-2 with combinational response.
  tcb_lite_lib_arbiter_rr #(.IFN(4), .DLY(1), .MAXBST(4)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_vld_i(req_vld), .req_lck_i(req_lck),
    .man_rdy_i(man_rdy), .gnt_o(a_gnt), .sel_o(a_sel), .man_vld_o(a_mv),
    .rsp_vld_o(a_rv), .rsp_sel_o(a_rs), .lck_act_o(a_lk)
  );

  tcb_lite_lib_arbiter_rr #(.IFN(4), .DLY(3), .MAXBST(8)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_vld_i(req_vld), .req_lck_i(req_lck),
    .man_rdy_i(man_rdy), .gnt_o(b_gnt), .sel_o(b_sel), .man_vld_o(b_mv),
    .rsp_vld_o(b_rv), .rsp_sel_o(b_rs), .lck_act_o(b_lk)
  );

  tcb_lite_lib_arbiter_rr #(.IFN(3), .DLY(0), .MAXBST(2)) u_dut_c (
    .clk_i(clk), .rst_ni(rst_n), .req_vld_i(req_vld[2:0]), .req_lck_i(req_lck[2:0]),
    .man_rdy_i(man_rdy), .gnt_o(c_gnt), .sel_o(c_sel), .man_vld_o(c_mv),
    .rsp_vld_o(c_rv), .rsp_sel_o(c_rs), .lck_act_o(c_lk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change just after the edge; outputs are sampled mid-cycle.
  task automatic apply(input logic r, input logic [3:0] v, input logic [3:0] l, input logic y);
    @(posedge clk);
    #1;
    rst_n   = r;
    req_vld = v;
    req_lck = l;
    man_rdy = y;
    #2;
  endtask

  task automatic do_reset();
    apply(1'b0, 4'b0000, 4'b0000, 1'b1);
    apply(1'b0, 4'b1111, 4'b0000, 1'b1);
  endtask

  int         exp_sel1 [5] = '{0, 1, 2, 3, 0};
  logic [3:0] exp_gnt3 [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1000, 4'b0001};
  logic       exp_lck3 [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [3:0] req5     [3] = '{4'b1000, 4'b0001, 4'b0100};
  int         exp_rs5  [3] = '{3, 0, 2};
  int         exp_selc [5] = '{0, 1, 2, 0, 1};

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    req_vld = '0;
    req_lck = '0;
    man_rdy = 1'b0;

    // Reset outputs while held in reset with all requests up.
    do_reset();
    check("rst_gnt", a_gnt, 4'b0000);
    check("rst_sel", a_sel, 2'd0);
    check("rst_mvld", a_mv, 1'b0);
    check("rst_rvld", a_rv, 1'b0);
    check("rst_lck", a_lk, 1'b0);

    // 1: full rotation, response one cycle behind.
    for (int k = 0; k < 5; k++) begin
      apply(1'b1, 4'b1111, 4'b0000, 1'b1);
      check("t1_sel", a_sel, exp_sel1[k]);
      check("t1_mvld", a_mv, 1'b1);
      check("t1_rvld", a_rv, (k > 0) ? 1'b1 : 1'b0);
      if (k > 0) check("t1_rsel", a_rs, exp_sel1[k-1]);
    end

    // 2: requester 2 locks for three transfers, releases on the fourth.
    do_reset();
    apply(1'b1, 4'b0100, 4'b0100, 1'b1);
    check("t2_gnt0", a_gnt, 4'b0100);
    check("t2_lck0", a_lk, 1'b0);
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, 4'b0110, (k < 2) ? 4'b0100 : 4'b0000, 1'b1);
      check("t2_gnt", a_gnt, 4'b0100);
      check("t2_lck", a_lk, 1'b1);
    end
    apply(1'b1, 4'b0110, 4'b0000, 1'b1);
    check("t2_next", a_gnt, 4'b0010);
    check("t2_unlk", a_lk, 1'b0);

    // 3: permanent lock by 0 is forcibly released after MAXBST locked transfers.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      apply(1'b1, 4'b1001, 4'b0001, 1'b1);
      check("t3_gnt", a_gnt, exp_gnt3[k]);
      check("t3_lck", a_lk, exp_lck3[k]);
    end

    // 4: stall holds grant, no pointer movement, no response for stalled cycles.
    do_reset();
    apply(1'b1, 4'b0001, 4'b0000, 1'b1);
    check("t4_pre", a_sel, 2'd0);
    for (int k = 0; k < 5; k++) begin
      apply(1'b1, 4'b0110, 4'b0000, 1'b0);
      check("t4_sel", a_sel, 2'd1);
      check("t4_gnt", a_gnt, 4'b0010);
      check("t4_rvld", a_rv, (k == 0) ? 1'b1 : 1'b0);
    end
    apply(1'b1, 4'b0111, 4'b0000, 1'b0);
    check("t4_nopre", a_sel, 2'd1);
    check("t4_rvld_s", a_rv, 1'b0);
    apply(1'b1, 4'b0111, 4'b0000, 1'b1);
    check("t4_go", a_sel, 2'd1);
    apply(1'b1, 4'b0111, 4'b0000, 1'b1);
    check("t4_after", a_sel, 2'd2);
    check("t4_rsel", a_rs, 2'd1);
    check("t4_rvld1", a_rv, 1'b1);

    // 5: DLY=3 response routing.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, req5[k], 4'b0000, 1'b1);
      check("t5_sel", b_sel, exp_rs5[k]);
      check("t5_rvld0", b_rv, 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, 4'b0000, 4'b0000, 1'b1);
      check("t5_rvld", b_rv, 1'b1);
      check("t5_rsel", b_rs, exp_rs5[k]);
    end
    apply(1'b1, 4'b0000, 4'b0000, 1'b1);
    check("t5_tail", b_rv, 1'b0);

    // 6: reset during lock with two responses in flight.
    do_reset();
    apply(1'b1, 4'b0010, 4'b0010, 1'b1);
    check("t6_gnt", b_gnt, 4'b0010);
    apply(1'b1, 4'b0010, 4'b0010, 1'b1);
    check("t6_lck", b_lk, 1'b1);
    apply(1'b0, 4'b1111, 4'b0000, 1'b1);
    check("t6_rgnt", b_gnt, 4'b0000);
    apply(1'b1, 4'b1111, 4'b0000, 1'b1);
    check("t6_unlk", b_lk, 1'b0);
    check("t6_rv0", b_rv, 1'b0);
    check("t6_first", b_gnt, 4'b0001);
    apply(1'b1, 4'b0000, 4'b0000, 1'b1);
    check("t6_rv1", b_rv, 1'b0);
    apply(1'b1, 4'b0000, 4'b0000, 1'b1);
    check("t6_rv2", b_rv, 1'b0);

    // IFN=3 wrap and DLY=0 combinational response.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      apply(1'b1, 4'b0111, 4'b0000, 1'b1);
      check("c_sel", c_sel, exp_selc[k]);
      check("c_rvld", c_rv, 1'b1);
      check("c_rsel", c_rs, exp_selc[k]);
    end
    apply(1'b1, 4'b0111, 4'b0000, 1'b0);
    check("c_stall", c_rv, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
